// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C gain-register controller: FSM states,
// gain register addresses and the R/W bit values.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      TX_BIT,
      RX_ACK,
      RESTART,
      RX_BIT,
      TX_NACK,
      STOP,
      DONE
   } state_e;

   localparam logic [7:0] K_P_ADDR = 8'd0;
   localparam logic [7:0] K_I_ADDR = 8'd1;
   localparam logic [7:0] K_D_ADDR = 8'd2;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   function automatic logic [7:0] addrByte(input logic [6:0] dev, input logic rw);
      return {dev, rw};
   endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period prescaler: one-cycle tick every CLK_DIV enabled cycles
// plus a free-running 2-bit quarter index, both cleared on command accept.
module i2c_quarter_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ena_i,
   input  logic       clear_i,
   output logic       tick_o,
   output logic [1:0] quarter_o
);

   logic [7:0] cnt_q, cnt_d;
   logic [1:0] quarter_q, quarter_d;

   always_comb begin
      tick_o    = ena_i && (cnt_q == 8'(CLK_DIV - 1));
      cnt_d     = cnt_q;
      quarter_d = quarter_q;
      if (clear_i) begin
         cnt_d     = 8'd0;
         quarter_d = 2'd0;
      end else if (tick_o) begin
         cnt_d     = 8'd0;
         quarter_d = quarter_q + 2'd1;
      end else if (ena_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q     <= 8'd0;
         quarter_q <= 2'd0;
      end else begin
         cnt_q     <= cnt_d;
         quarter_q <= quarter_d;
      end
   end

   assign quarter_o = quarter_q;

endmodule

// File: rtl/i2c_gain_master.sv
// Bit-level I2C initiator that writes/reads the 6-bit PID gain registers of a
// target, one command at a time, over open-drain SCL/SDA.
module i2c_gain_master
   import i2c_pkg::*;
#(
   parameter int         CLK_DIV  = 4,
   parameter logic [6:0] DEV_ADDR = 7'h2A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_reg_addr,
   input  logic [5:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [5:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       busy,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in
);

   state_e     state_q, state_d;
   logic [2:0] bitCnt_q, bitCnt_d;
   logic [1:0] byteIdx_q, byteIdx_d;
   logic       nack_q, nack_d;
   logic [5:0] rx_q, rx_d;
   logic [5:0] rdata_q, rdata_d;
   logic       rw_q;
   logic [7:0] regAddr_q;
   logic [5:0] wdata_q;

   logic       tick, lastQ, sampleQ, accept;
   logic [1:0] quarter;
   logic [7:0] curByte;
   logic       sclLow, sdaLow;

   i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) uTick (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .ena_i     (ena),
      .clear_i   (accept),
      .tick_o    (tick),
      .quarter_o (quarter)
   );

   assign cmd_ready = rst_n && ena && (state_q == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign lastQ     = tick && (quarter == 2'd3);
   assign sampleQ   = tick && (quarter == 2'd2);

   // Byte index 2 is the data byte on writes and the repeated address on reads.
   always_comb begin
      case (byteIdx_q)
         2'd0:    curByte = addrByte(DEV_ADDR, RW_WRITE);
         2'd1:    curByte = regAddr_q;
         2'd2:    curByte = (rw_q == RW_READ) ? addrByte(DEV_ADDR, RW_READ) : {2'b00, wdata_q};
         default: curByte = 8'h00;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      bitCnt_d  = bitCnt_q;
      byteIdx_d = byteIdx_q;
      nack_d    = nack_q;
      rx_d      = rx_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               nack_d  = 1'b0;
            end
         end
         START: begin
            if (lastQ) begin
               state_d   = TX_BIT;
               bitCnt_d  = 3'd7;
               byteIdx_d = 2'd0;
            end
         end
         TX_BIT: begin
            if (lastQ) begin
               if (bitCnt_q == 3'd0) state_d = RX_ACK;
               else                  bitCnt_d = bitCnt_q - 3'd1;
            end
         end
         RX_ACK: begin
            if (sampleQ && sda_in) nack_d = 1'b1;
            if (lastQ) begin
               bitCnt_d = 3'd7;
               if (nack_q) begin
                  state_d = STOP;
               end else begin
                  case (byteIdx_q)
                     2'd0: begin
                        state_d   = TX_BIT;
                        byteIdx_d = 2'd1;
                     end
                     2'd1: begin
                        if (rw_q == RW_READ) begin
                           state_d = RESTART;
                        end else begin
                           state_d   = TX_BIT;
                           byteIdx_d = 2'd2;
                        end
                     end
                     default: state_d = (rw_q == RW_READ) ? RX_BIT : STOP;
                  endcase
               end
            end
         end
         RESTART: begin
            if (lastQ) begin
               state_d   = TX_BIT;
               bitCnt_d  = 3'd7;
               byteIdx_d = 2'd2;
            end
         end
         RX_BIT: begin
            if (sampleQ) rx_d = {rx_q[4:0], sda_in};
            if (lastQ) begin
               if (bitCnt_q == 3'd0) state_d = TX_NACK;
               else                  bitCnt_d = bitCnt_q - 3'd1;
            end
         end
         TX_NACK: begin
            if (lastQ) state_d = STOP;
         end
         STOP: begin
            if (lastQ) begin
               state_d = DONE;
               if (rw_q == RW_READ && !nack_q) rdata_d = rx_q;
            end
         end
         DONE: begin
            if (ena) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sclLow = 1'b0;
      sdaLow = 1'b0;
      case (state_q)
         START: begin
            sdaLow = quarter[1];
            sclLow = (quarter == 2'd3);
         end
         TX_BIT: begin
            sclLow = ~quarter[1];
            sdaLow = ~curByte[bitCnt_q];
         end
         RX_ACK, RX_BIT, TX_NACK: sclLow = ~quarter[1];
         RESTART: begin
            sclLow = (quarter == 2'd0) || (quarter == 2'd3);
            sdaLow = quarter[1];
         end
         STOP: begin
            sclLow = (quarter == 2'd0);
            sdaLow = ~quarter[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bitCnt_q  <= 3'd0;
         byteIdx_q <= 2'd0;
         nack_q    <= 1'b0;
         rx_q      <= 6'd0;
         rdata_q   <= 6'd0;
      end else begin
         state_q   <= state_d;
         bitCnt_q  <= bitCnt_d;
         byteIdx_q <= byteIdx_d;
         nack_q    <= nack_d;
         rx_q      <= rx_d;
         rdata_q   <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rw_q      <= RW_WRITE;
         regAddr_q <= 8'd0;
         wdata_q   <= 6'd0;
      end else if (accept) begin
         rw_q      <= cmd_rw;
         regAddr_q <= cmd_reg_addr;
         wdata_q   <= cmd_wdata;
      end
   end

   // Gating with rst_n releases the bus in the very cycle reset is asserted.
   assign scl_oe    = rst_n && sclLow;
   assign sda_oe    = rst_n && sdaLow;
   assign rsp_valid = rst_n && (state_q == DONE);
   assign rsp_nack  = rsp_valid && nack_q;
   assign rsp_rdata = rdata_q;
   assign busy      = rst_n && ((state_q != IDLE) || accept);

endmodule

// File: tb/tb_i2c_gain_master.sv
// Directed bench for i2c_gain_master with a behavioural I2C target that
// decodes START/STOP, captures received bytes, ACKs and serves read data.
module tb_i2c_gain_master;
   import i2c_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_rw = 1'b0;
   logic [7:0] cmd_reg_addr = 8'd0;
   logic [5:0] cmd_wdata = 6'd0;
   logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe, sda_in;
   logic [5:0] rsp_rdata;

   logic       tgtPull = 1'b0;
   logic       tgtPresent = 1'b1;
   logic [7:0] rdByte = 8'h00;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int acceptCyc = 0;
   int lastRspCyc = 0;
   int rspPulses = 0;

   i2c_gain_master dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena          (ena),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_rw       (cmd_rw),
      .cmd_reg_addr (cmd_reg_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_nack     (rsp_nack),
      .busy         (busy),
      .scl_oe       (scl_oe),
      .sda_oe       (sda_oe),
      .sda_in       (sda_in)
   );

   assign sda_in = !(sda_oe || tgtPull);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (rsp_valid) rspPulses++;

   // Behavioural target, evaluated on the falling system clock.
   logic       sclPrev = 1'b1, sdaPrev = 1'b1;
   int         frameBit = 0;
   logic [7:0] shiftIn = 8'h00;
   logic       txMode = 1'b0, firstByte = 1'b0;
   logic       masterAckBit = 1'b0;
   logic [7:0] rxBytes[$];
   int         startCnt = 0, stopCnt = 0;

   always @(negedge clk) begin
      logic sclNow, sdaNow;
      sclNow = !scl_oe;
      sdaNow = sda_in;
      if (sclPrev && sclNow && sdaPrev && !sdaNow) begin
         startCnt++;
         frameBit = 0; txMode = 1'b0; firstByte = 1'b1; tgtPull = 1'b0;
      end else if (sclPrev && sclNow && !sdaPrev && sdaNow) begin
         stopCnt++;
         frameBit = 0; txMode = 1'b0; tgtPull = 1'b0;
      end else if (!sclPrev && sclNow) begin
         if (frameBit < 8) begin
            if (!txMode) shiftIn = {shiftIn[6:0], sdaNow};
            frameBit++;
            if (frameBit == 8 && !txMode) rxBytes.push_back(shiftIn);
         end else begin
            if (txMode) begin
               masterAckBit = sdaNow;
               if (sdaNow) txMode = 1'b0;
            end else if (firstByte && shiftIn[0] && tgtPresent) begin
               txMode = 1'b1;
            end
            firstByte = 1'b0;
            frameBit = 0;
         end
      end else if (sclPrev && !sclNow) begin
         if (frameBit == 8 && !txMode) tgtPull = tgtPresent;
         else if (txMode && frameBit < 8) tgtPull = !rdByte[7 - frameBit];
         else tgtPull = 1'b0;
      end
      sclPrev = sclNow;
      sdaPrev = sdaNow;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Called just after a falling edge; returns at the falling edge of the response cycle.
   task automatic applyStimulus(input logic rw, input logic [7:0] ra, input logic [5:0] wd,
                                input int enaLowAt, input int rstAt,
                                output int lat, output logic [5:0] rd, output logic nk);
      int   k;
      int   wait4;
      int   holdErr;
      logic gotRsp;
      logic sclHold, sdaHold;
      lat = -1; rd = 6'h00; nk = 1'b0; gotRsp = 1'b0; holdErr = 0;
      sclHold = 1'b0; sdaHold = 1'b0;
      cmd_rw = rw; cmd_reg_addr = ra; cmd_wdata = wd; cmd_valid = 1'b1;
      wait4 = 0;
      while (!cmd_ready && wait4 < 50) begin
         @(negedge clk);
         wait4++;
      end
      checkOutput("acceptReady", 32'(cmd_ready), 32'd1);
      acceptCyc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_rw = ~rw; cmd_reg_addr = ~ra; cmd_wdata = ~wd;
      checkOutput("busyAfterAccept", 32'(busy), 32'd1);
      while (!gotRsp && (cyc - acceptCyc) < 1200) begin
         k = cyc - acceptCyc;
         if (rstAt > 0 && k == rstAt) begin
            checkOutput("preRstScl", 32'(scl_oe), 32'd1);
            rst_n = 1'b0;
            #1;
            checkOutput("rstScl", 32'(scl_oe), 32'd0);
            checkOutput("rstSda", 32'(sda_oe), 32'd0);
            checkOutput("rstBusy", 32'(busy), 32'd0);
            checkOutput("rstReady", 32'(cmd_ready), 32'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            #1;
            checkOutput("readyAfterRst", 32'(cmd_ready), 32'd1);
            break;
         end
         if (enaLowAt > 0 && k == enaLowAt) begin
            ena = 1'b0;
            sclHold = scl_oe;
            sdaHold = sda_oe;
         end
         if (enaLowAt > 0 && k > enaLowAt && k <= enaLowAt + 100 &&
             (scl_oe !== sclHold || sda_oe !== sdaHold)) holdErr++;
         if (enaLowAt > 0 && k == enaLowAt + 100) ena = 1'b1;
         if (rsp_valid) begin
            gotRsp = 1'b1;
            lat = k;
            rd = rsp_rdata;
            nk = rsp_nack;
            lastRspCyc = cyc;
         end else begin
            @(negedge clk);
         end
      end
      if (rstAt == 0) checkOutput("rspSeen", 32'(gotRsp), 32'd1);
      if (enaLowAt > 0) checkOutput("enaLinesHold", 32'(holdErr), 32'd0);
   endtask

   initial begin
      int         lat, firstRsp, savedPulses, savedStops;
      logic [5:0] rd;
      logic       nk;

      repeat (3) @(negedge clk);
      checkOutput("resetScl", 32'(scl_oe), 32'd0);
      checkOutput("resetSda", 32'(sda_oe), 32'd0);
      checkOutput("resetReady", 32'(cmd_ready), 32'd0);
      checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
      checkOutput("resetRspNack", 32'(rsp_nack), 32'd0);
      checkOutput("resetRdata", 32'(rsp_rdata), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write K_i = 0x15
      $display("[TB] write K_i");
      rxBytes.delete(); startCnt = 0; stopCnt = 0; tgtPresent = 1'b1;
      applyStimulus(RW_WRITE, K_I_ADDR, 6'h15, 0, 0, lat, rd, nk);
      checkOutput("wrLatency", 32'(lat), 32'd465);
      checkOutput("wrNack", 32'(nk), 32'd0);
      @(negedge clk); #1;
      checkOutput("wrRspOneCycle", 32'(rsp_valid), 32'd0);
      checkOutput("wrReadyAfterDone", 32'(cmd_ready), 32'd1);
      checkOutput("wrByteCount", 32'(rxBytes.size()), 32'd3);
      checkOutput("wrByte0", 32'(rxBytes[0]), 32'h54);
      checkOutput("wrByte1", 32'(rxBytes[1]), 32'h01);
      checkOutput("wrByte2", 32'(rxBytes[2]), 32'h15);
      checkOutput("wrStarts", 32'(startCnt), 32'd1);
      checkOutput("wrStops", 32'(stopCnt), 32'd1);

      // Read K_d, target returns 0xEB
      $display("[TB] read K_d");
      rxBytes.delete(); startCnt = 0; stopCnt = 0; rdByte = 8'hEB; masterAckBit = 1'b0;
      applyStimulus(RW_READ, K_D_ADDR, 6'h00, 0, 0, lat, rd, nk);
      checkOutput("rdLatency", 32'(lat), 32'd625);
      checkOutput("rdData", 32'(rd), 32'h2B);
      checkOutput("rdNack", 32'(nk), 32'd0);
      @(negedge clk); #1;
      checkOutput("rdByteCount", 32'(rxBytes.size()), 32'd3);
      checkOutput("rdByte0", 32'(rxBytes[0]), 32'h54);
      checkOutput("rdByte1", 32'(rxBytes[1]), 32'h02);
      checkOutput("rdByte2", 32'(rxBytes[2]), 32'h55);
      checkOutput("rdStarts", 32'(startCnt), 32'd2);
      checkOutput("rdStops", 32'(stopCnt), 32'd1);
      checkOutput("rdMasterNack", 32'(masterAckBit), 32'd1);

      // No target on the bus
      $display("[TB] absent target");
      rxBytes.delete(); stopCnt = 0; tgtPresent = 1'b0;
      applyStimulus(RW_READ, K_P_ADDR, 6'h00, 0, 0, lat, rd, nk);
      checkOutput("nackLatency", 32'(lat), 32'd177);
      checkOutput("nackFlag", 32'(nk), 32'd1);
      checkOutput("nackRdataHeld", 32'(rd), 32'h2B);
      @(negedge clk); #1;
      checkOutput("nackByteCount", 32'(rxBytes.size()), 32'd1);
      checkOutput("nackStops", 32'(stopCnt), 32'd1);
      tgtPresent = 1'b1;

      // Reset during the register-address byte
      $display("[TB] reset mid-transaction");
      savedPulses = rspPulses; savedStops = stopCnt;
      applyStimulus(RW_WRITE, K_I_ADDR, 6'h0A, 0, 200, lat, rd, nk);
      repeat (600) @(negedge clk);
      #1;
      checkOutput("rstNoRsp", 32'(rspPulses - savedPulses), 32'd0);
      checkOutput("rstNoStop", 32'(stopCnt - savedStops), 32'd0);

      // ena low for 100 cycles mid-byte
      $display("[TB] enable stall");
      rxBytes.delete();
      applyStimulus(RW_WRITE, K_D_ADDR, 6'h2A, 200, 0, lat, rd, nk);
      checkOutput("stallLatency", 32'(lat), 32'd565);
      checkOutput("stallNack", 32'(nk), 32'd0);
      @(negedge clk); #1;
      checkOutput("stallData", 32'(rxBytes[2]), 32'h2A);

      // Back-to-back writes to K_p
      $display("[TB] back-to-back writes");
      rxBytes.delete(); savedPulses = rspPulses;
      applyStimulus(RW_WRITE, K_P_ADDR, 6'h3F, 0, 0, lat, rd, nk);
      checkOutput("b2bLat1", 32'(lat), 32'd465);
      firstRsp = lastRspCyc;
      applyStimulus(RW_WRITE, K_P_ADDR, 6'h00, 0, 0, lat, rd, nk);
      checkOutput("b2bAcceptGap", 32'(acceptCyc - firstRsp), 32'd1);
      checkOutput("b2bLat2", 32'(lat), 32'd465);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("b2bPulses", 32'(rspPulses - savedPulses), 32'd2);
      checkOutput("b2bFirstData", 32'(rxBytes[2]), 32'h3F);
      checkOutput("b2bFinalData", 32'(rxBytes[5]), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/i2c_gain_master.md
# i2c_gain_master

Bit-level I2C controller that writes and reads the 6-bit PID gain registers (K_p, K_i, K_d) of an I2C target over an open-drain SCL/SDA pair. It is the initiator end of the gain-register interface. It is used on the bring-up/host side of the design and as the stimulus engine for target-side verification. Accepts one register command at a time through a valid/ready port and returns a one-cycle response with read data and NACK status.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-period; legal range 1..255.
- DEV_ADDR, 7'h2A: 7-bit target address sent in every address byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  enable; low freezes all sequencing (counters and state hold, lines hold).
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with ena=1; a command is accepted when cmd_valid && cmd_ready.
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_reg_addr  in  8  register address: 0 = K_p, 1 = K_i, 2 = K_d. Other values are sent unchanged.
- cmd_wdata  in  6  write value; transmitted as data byte {2'b00, cmd_wdata}.
- rsp_valid  out  1  one-cycle pulse when a transaction completes.
- rsp_rdata  out  6  low 6 bits of the received byte; valid with rsp_valid on reads; holds until the next read completes.
- rsp_nack  out  1  valid with rsp_valid; 1 = target failed to ACK some byte.
- busy  out  1  high from the accept cycle through the rsp_valid cycle.
- scl_oe  out  1  1 = pull SCL low, 0 = release.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- sda_in  in  1  sampled SDA line (already synchronised externally).

## Operation
- Reset values: scl_oe=0, sda_oe=0, cmd_ready=0 during reset, rsp_valid=0, rsp_nack=0, rsp_rdata=0, busy=0. State returns to IDLE.
- Command fields are latched on accept; inputs are don't-care afterwards.
- Write sequence: START, {DEV_ADDR,0}, ACK, reg_addr, ACK, data, ACK, STOP.
- Read sequence: START, {DEV_ADDR,0}, ACK, reg_addr, ACK, RESTART, {DEV_ADDR,1}, ACK, 8 data bits, master NACK (SDA released), STOP.
- Bytes are sent MSB first.
- States: IDLE, START, TX_BIT, RX_ACK, RESTART, RX_BIT, TX_NACK, STOP, DONE. A 3-bit bit counter and a 2-bit byte index select the next byte.
- If sda_in=1 at any RX_ACK sample, the controller skips the remaining bytes, goes to STOP, and completes with rsp_nack=1. rsp_rdata is unchanged in that case.
- DONE lasts exactly one cycle: rsp_valid=1, then IDLE.
- No clock stretching and no arbitration. SCL is never sampled.
- Reset mid-transaction: both lines are released in the reset cycle. No STOP is generated and no rsp_valid is produced.

## Timing
- One quarter tick every CLK_DIV enabled cycles. One bit period = 4 quarters (q0..q3).
- Data/ACK bit: q0–q1 SCL low, with SDA updated at the q0 start; q2–q3 SCL released. sda_in is sampled on the last cycle of q2.
- START (IDLE→START): q0–q1 both released; q2 SDA low; q3 SDA low and SCL low.
- RESTART: q0 SCL low, SDA released; q1 SCL released; q2 SDA low; q3 SCL low.
- STOP: q0 SCL low, SDA low; q1 SCL released; q2–q3 SDA released.
- Write latency: 29 bit periods (START + 27 bits + STOP). rsp_valid fires in the cycle after the last STOP quarter, i.e. 29*4*CLK_DIV+1 cycles after accept. With CLK_DIV=4 that is cycle 465.
- Read latency: 39 bit periods (START + 18 bits + RESTART + 18 bits + STOP). The response lands 39*4*CLK_DIV+1 cycles after accept.
- ena low stalls the quarter counter. Latency is extended by exactly the number of ena-low cycles.
- cmd_ready rises the cycle after DONE. Back-to-back commands are therefore separated by ≥1 idle cycle.

## Structure
- Shared package `i2c_pkg`: state enum, gain register addresses (K_P_ADDR=0, K_I_ADDR=1, K_D_ADDR=2), and the RW bit constants.
- Sub-module `i2c_quarter_tick`: CLK_DIV prescaler with ena gating and a synchronous clear on accept. It outputs a 1-cycle tick plus the 2-bit quarter index.

## Test plan
- Write K_i=6'h15 to an ACKing behavioural target: the target captures bytes 0x54, 0x01, 0x15. rsp_valid appears at cycle 465 (CLK_DIV=4) with rsp_nack=0. START and STOP edges occur while SCL is high.
- Read K_d while the target returns 0xEB: the bus carries 0x54, 0x02, RESTART, 0x55. The master NACKs the data byte. rsp_rdata=6'h2B, rsp_nack=0, at cycle 625.
- No target present (sda_in stuck 1): rsp_nack=1 after the address ACK slot. STOP is generated, and rsp_valid comes 11 bit periods after accept.
- Reset asserted during the reg_addr byte: scl_oe=sda_oe=0 in the same cycle. No rsp_valid follows. cmd_ready=1 in the first cycle after rst_n rises.
- ena held low for 100 cycles mid-byte: SCL/SDA hold their levels, and the response is delayed by exactly 100 cycles.
- Two back-to-back writes (K_p=6'h3F, then K_p=6'h00): both complete, the second is accepted the cycle after the first DONE, and the target ends with 0x00.
